mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and select sequencer for the 8:1 mux datapath.
- Shares the single mux output between eight requesters, one at a time.
- Drives the 3-bit mux select (sel[2]→s2, sel[1]→s1, sel[0]→s0), a one-hot grant vector and a valid flag.
- Enforces an optional per-grant hold limit so one requester cannot monopolise the mux.

---
 rtl/mux8_rr_arbiter_pkg.sv | 20 ++
 rtl/mux8_rr_arbiter_if.sv | 23 ++
 rtl/mux8_rr_arbiter_rr_pick8.sv | 30 +++
 rtl/mux8_rr_arbiter.sv | 89 ++++++++
 tb/tb_mux8_rr_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-input round-robin mux arbiter:
// requester count, FSM state encoding and a one-hot helper.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [2:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the eight mux requesters and the arbiter.
// "owner_release" is the owner's end-of-grant pulse ("release" is a reserved word).
interface mux8_rr_arbiter_if;
  import mux8_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             owner_release;
  logic [N_REQ-1:0] grant;
  logic [2:0]       sel;
  logic             grant_valid;
  logic             preempt;

  modport master (
    output req, owner_release,
    input  grant, sel, grant_valid, preempt
  );

  modport slave (
    input  req, owner_release,
    output grant, sel, grant_valid, preempt
  );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 8.
// Rotate so ptr lands at bit 0, fixed-priority encode, then add ptr back.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       winner,
  output logic             any
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [2:0]         offset;

  assign doubled = {req, req};
  assign rotated = N_REQ'(doubled >> ptr);

  // Scanning downward lets the lowest set bit of the rotated vector win.
  always_comb begin
    offset = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = i[2:0];
    end
  end

  assign winner = ptr + offset;
  assign any    = |req;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sequencing the 8:1 mux select, with a one-cycle
// settling gap between owners and an optional hold-limit preemption.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  mux8_rr_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [N_REQ-1:0] grant_reg;
  logic [2:0]       sel_reg;
  logic             valid_reg;
  logic             preempt_reg;

  logic [2:0] winner;
  logic       any;
  logic       owner_drop;
  logic       timeout;
  logic       end_grant;

  rr_pick8 u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign owner_drop = ~bus.req[sel_reg];
  assign timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign end_grant  = bus.owner_release | owner_drop | timeout;

  // Preempt is flagged only when the hold limit alone ended the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= 3'd0;
      hold_cnt    <= '0;
      grant_reg   <= '0;
      sel_reg     <= 3'd0;
      valid_reg   <= 1'b0;
      preempt_reg <= 1'b0;
    end else begin
      preempt_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            state     <= ST_BUSY;
            grant_reg <= onehot8(winner);
            sel_reg   <= winner;
            valid_reg <= 1'b1;
            ptr       <= winner + 3'd1;
            hold_cnt  <= '0;
          end
        end
        ST_BUSY: begin
          if (hold_cnt != {CNT_W{1'b1}}) hold_cnt <= hold_cnt + CNT_W'(1);
          if (end_grant) begin
            state       <= ST_GAP;
            grant_reg   <= '0;
            valid_reg   <= 1'b0;
            preempt_reg <= timeout & ~bus.owner_release & ~owner_drop;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.sel         = sel_reg;
  assign bus.grant_valid = valid_reg;
  assign bus.preempt     = preempt_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 16;

  logic clk;
  logic rst;
  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner index (-1 = none), gap flag, pointer, BUSY cycles elapsed.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_sel   = 0;
  bit m_pre   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input logic [7:0] r, input bit rl, input bit rs);
    bit ended;
    if (rs) begin
      m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_hold = 0; m_sel = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_owner >= 0) begin
        m_hold++;
        ended = rl || !r[m_owner] || (MAX_HOLD != 0 && m_hold == MAX_HOLD);
        if (ended) begin
          m_pre   = !(rl || !r[m_owner]);
          m_owner = -1;
          m_gap   = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (r[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            break;
          end
        end
        m_sel  = m_owner;
        m_ptr  = (m_owner + 1) % 8;
        m_hold = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input bit rl, input bit rs);
    logic [7:0] exp_grant;
    @(negedge clk);
    bus.req           = r;
    bus.owner_release = rl;
    rst               = rs;
    @(posedge clk);
    modelStep(r, rl, rs);
    #1;
    exp_grant = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    checkOutput("grant", 32'(bus.grant), 32'(exp_grant));
    checkOutput("sel", 32'(bus.sel), 32'(m_sel));
    checkOutput("grant_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
    checkOutput("preempt", 32'(bus.preempt), 32'(m_pre));
    checkOutput("onehot0", 32'($onehot0(bus.grant)), 32'd1);
  endtask

  int busy_cycles;
  logic [7:0] rnd_req;

  initial begin
    bus.req = 8'h00;
    bus.owner_release = 1'b0;
    rst = 1'b1;

    // Reset state
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("rst_grant", 32'(bus.grant), 32'h0);
    checkOutput("rst_valid", 32'(bus.grant_valid), 32'h0);

    // First grant and release turnaround
    applyStimulus(8'h24, 1'b0, 1'b0);
    checkOutput("first_grant", 32'(bus.grant), 32'h04);
    checkOutput("first_sel", 32'(bus.sel), 32'd2);
    applyStimulus(8'h24, 1'b1, 1'b0);
    checkOutput("gap_grant", 32'(bus.grant), 32'h0);
    applyStimulus(8'h24, 1'b0, 1'b0);
    applyStimulus(8'h24, 1'b0, 1'b0);
    checkOutput("second_grant", 32'(bus.grant), 32'h20);
    checkOutput("second_sel", 32'(bus.sel), 32'd5);

    // Full rotation with all requesting
    applyStimulus(8'hFF, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      checkOutput("rot_sel", 32'(bus.sel), 32'(k % 8));
      checkOutput("rot_grant", 32'(bus.grant), 32'(8'h01 << (k % 8)));
      repeat (3) applyStimulus(8'hFF, 1'b0, 1'b0);
      applyStimulus(8'hFF, 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b0, 1'b0);
      applyStimulus(8'hFF, 1'b0, 1'b0);
    end

    // Single requester runs into the hold limit
    applyStimulus(8'h01, 1'b0, 1'b1);
    applyStimulus(8'h01, 1'b0, 1'b0);
    busy_cycles = 1;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(8'h01, 1'b0, 1'b0);
      if (bus.grant_valid) begin
        busy_cycles++;
      end else begin
        checkOutput("timeout_preempt", 32'(bus.preempt), 32'd1);
        break;
      end
    end
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(MAX_HOLD));
    applyStimulus(8'h01, 1'b0, 1'b0);
    checkOutput("preempt_one_cycle", 32'(bus.preempt), 32'd0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    checkOutput("regrant", 32'(bus.grant), 32'h01);

    // Owner withdraws its request
    applyStimulus(8'h81, 1'b0, 1'b1);
    applyStimulus(8'h81, 1'b0, 1'b0);
    checkOutput("drop_owner", 32'(bus.grant), 32'h01);
    applyStimulus(8'h80, 1'b0, 1'b0);
    checkOutput("drop_clear", 32'(bus.grant), 32'h0);
    checkOutput("drop_no_preempt", 32'(bus.preempt), 32'd0);
    applyStimulus(8'h80, 1'b0, 1'b0);
    applyStimulus(8'h80, 1'b0, 1'b0);
    checkOutput("drop_next", 32'(bus.grant), 32'h80);

    // Reset in the middle of a grant
    applyStimulus(8'h10, 1'b0, 1'b1);
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("mid_grant", 32'(bus.grant), 32'h10);
    applyStimulus(8'h10, 1'b0, 1'b1);
    checkOutput("mid_rst_grant", 32'(bus.grant), 32'h0);
    checkOutput("mid_rst_sel", 32'(bus.sel), 32'd0);
    checkOutput("mid_rst_preempt", 32'(bus.preempt), 32'd0);
    applyStimulus(8'h80, 1'b0, 1'b0);
    checkOutput("post_rst_grant", 32'(bus.grant), 32'h80);

    // Random traffic against the model
    rnd_req = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) rnd_req = 8'($urandom);
      applyStimulus(rnd_req, ($urandom_range(7) == 0), ($urandom_range(199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
